// File: rtl/axi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_txn_arbiter
// Description : Round-robin load/store arbiter driving a single master port
//               through an IDLE/ISSUE/RELEASE/DONE handshake.
//               Optional watchdog is enabled with the TXN_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_txn_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_done,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic                  st_done,
    output logic                  err,
    output logic [1:0]            m_mode,
    output logic [ADDR_WIDTH-1:0] m_addra,
    output logic [ADDR_WIDTH-1:0] m_addrb,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_init_txn,
    input  logic                  m_txn_done,
    input  logic                  m_error
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue   = 2'd1;
    localparam logic [1:0] c_st_release = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [1:0] c_mode_idle  = 2'b00;
    localparam logic [1:0] c_mode_load  = 2'b01;
    localparam logic [1:0] c_mode_store = 2'b10;

    logic [1:0]            r_state;
    logic                  r_grant_st;
    logic                  r_last_st;
    logic                  r_err_sticky;
    logic [DATA_WIDTH-1:0] r_rdata_cap;
    logic                  r_ld_done;
    logic                  r_st_done;
    logic                  r_err;
    logic [1:0]            r_mode;
    logic                  r_init;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_ld_rdata;

    logic w_any_req;
    logic w_pick_st;
    logic w_timeout;

    assign w_any_req = ld_req | st_req;
    // On a tie the store side wins only if the previous grant went to load.
    assign w_pick_st = st_req & (~ld_req | ~r_last_st);

`ifdef TXN_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_stay;

    assign w_stay    = ((r_state == c_st_issue) && !m_txn_done) ||
                       ((r_state == c_st_release) && m_txn_done);
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) &&
                       ((r_state == c_st_issue) || (r_state == c_st_release));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_stay && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_grant_st   <= 1'b0;
            r_last_st    <= 1'b1;
            r_err_sticky <= 1'b0;
            r_rdata_cap  <= '0;
            r_ld_done    <= 1'b0;
            r_st_done    <= 1'b0;
            r_err        <= 1'b0;
            r_mode       <= c_mode_idle;
            r_init       <= 1'b0;
            r_addra      <= '0;
            r_addrb      <= '0;
            r_wdata      <= '0;
            r_ld_rdata   <= '0;
        end else begin
            r_ld_done <= 1'b0;
            r_st_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!m_txn_done && w_any_req) begin
                        r_state    <= c_st_issue;
                        r_init     <= 1'b1;
                        r_grant_st <= w_pick_st;
                        r_last_st  <= w_pick_st;
                        if (w_pick_st) begin
                            r_mode  <= c_mode_store;
                            r_addra <= st_addr;
                            r_wdata <= st_wdata;
                        end else begin
                            r_mode  <= c_mode_load;
                            r_addrb <= ld_addr;
                        end
                    end
                end
                c_st_issue: begin
                    if (w_timeout) begin
                        r_state   <= c_st_done;
                        r_init    <= 1'b0;
                        r_ld_done <= ~r_grant_st;
                        r_st_done <= r_grant_st;
                        r_err     <= 1'b1;
                    end else if (m_txn_done) begin
                        r_state      <= c_st_release;
                        r_init       <= 1'b0;
                        r_err_sticky <= m_error;
                        if (!r_grant_st) begin
                            r_rdata_cap <= m_rdata;
                        end
                    end
                end
                c_st_release: begin
                    if (w_timeout) begin
                        r_state   <= c_st_done;
                        r_ld_done <= ~r_grant_st;
                        r_st_done <= r_grant_st;
                        r_err     <= 1'b1;
                    end else if (!m_txn_done) begin
                        r_state   <= c_st_done;
                        r_ld_done <= ~r_grant_st;
                        r_st_done <= r_grant_st;
                        r_err     <= r_err_sticky;
                        // Publish load data only when the done pulse goes out.
                        if (!r_grant_st) begin
                            r_ld_rdata <= r_rdata_cap;
                        end
                    end
                end
                c_st_done: begin
                    r_state      <= c_st_idle;
                    r_mode       <= c_mode_idle;
                    r_err_sticky <= 1'b0;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign ld_done    = r_ld_done;
    assign st_done    = r_st_done;
    assign err        = r_err;
    assign ld_rdata   = r_ld_rdata;
    assign m_mode     = r_mode;
    assign m_init_txn = r_init;
    assign m_addra    = r_addra;
    assign m_addrb    = r_addrb;
    assign m_wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_txn_arbiter
// Description : Self-checking bench for axi_txn_arbiter with a master responder
//               and a behavioural arbitration/data model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_txn_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req, st_req, m_txn_done, m_error;
    logic [AW-1:0] ld_addr, st_addr;
    logic [DW-1:0] st_wdata, m_rdata;
    logic          ld_done, st_done, err, m_init_txn;
    logic [DW-1:0] ld_rdata, m_wdata;
    logic [1:0]    m_mode;
    logic [AW-1:0] m_addra, m_addrb;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations recorded by the master responder for one transfer.
    bit            obs_to, obs_extra;
    logic [1:0]    obs_mode, obs_mode_rel;
    logic [AW-1:0] obs_addra, obs_addrb;
    logic [DW-1:0] obs_wdata, obs_ldr;
    logic          obs_ldd, obs_std, obs_err;
    int            obs_lat;

    always #5 clk = ~clk;

    axi_txn_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_done(st_done),
        .err(err), .m_mode(m_mode), .m_addra(m_addra), .m_addrb(m_addrb),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_init_txn(m_init_txn),
        .m_txn_done(m_txn_done), .m_error(m_error)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ld_req = 1'b0; st_req = 1'b0; m_txn_done = 1'b0; m_error = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Master responder: waits for m_init_txn, answers after 'delay' cycles.
    task automatic master_serve(input int delay, input logic [DW-1:0] rdata, input logic merr);
        int k;
        obs_to = 0; obs_extra = 0; obs_lat = 0; obs_ldd = 0; obs_std = 0; obs_err = 0;
        obs_mode = 0; obs_mode_rel = 0; obs_addra = 0; obs_addrb = 0; obs_wdata = 0; obs_ldr = 0;
        k = 0;
        while (m_init_txn !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (m_init_txn !== 1'b1) begin obs_to = 1; return; end
        obs_mode = m_mode; obs_addra = m_addra; obs_addrb = m_addrb; obs_wdata = m_wdata;
        for (int i = 0; i < delay; i++) begin @(negedge clk); obs_lat++; end
        m_rdata = rdata; m_error = merr; m_txn_done = 1'b1;
        k = 0;
        do begin @(negedge clk); obs_lat++; k++; end while (m_init_txn !== 1'b0 && k < 50);
        obs_mode_rel = m_mode;
        m_txn_done = 1'b0; m_error = 1'b0; m_rdata = ~rdata;
        if (k >= 50) begin obs_to = 1; return; end
        k = 0;
        do begin @(negedge clk); obs_lat++; k++; end
        while (ld_done !== 1'b1 && st_done !== 1'b1 && k < 20);
        if (ld_done !== 1'b1 && st_done !== 1'b1) begin obs_to = 1; return; end
        obs_ldd = ld_done; obs_std = st_done; obs_err = err; obs_ldr = ld_rdata;
        @(negedge clk);
        obs_extra = ((ld_done | st_done | err) !== 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ld_done, st_done, err, m_init_txn, m_mode} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {ld_done, st_done, err, m_init_txn, m_mode});
        end
        n_cmp++;
        if ({m_addra, m_addrb, m_wdata, ld_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %0h/%0h/%0h/%0h expected all 0", m_addra, m_addrb, m_wdata, ld_rdata);
        end
    endtask

    task automatic test_store();
        st_addr = 32'hF0; st_wdata = 128'hE100; st_req = 1'b1;
        master_serve(3, '0, 1'b0);
        st_req = 1'b0;
        n_cmp++;
        if (obs_to) begin n_fail++; $display("FAIL store_timeout: got stalled expected completion"); end
        n_cmp++;
        if ({obs_mode, obs_mode_rel} !== 4'b1010) begin
            n_fail++; $display("FAIL store_mode: got %b/%b expected 10/10", obs_mode, obs_mode_rel);
        end
        n_cmp++;
        if (obs_addra !== 32'hF0 || obs_wdata !== 128'hE100 || obs_addrb !== 32'h0) begin
            n_fail++; $display("FAIL store_addr: got a=%0h w=%0h b=%0h expected f0 e100 0", obs_addra, obs_wdata, obs_addrb);
        end
        n_cmp++;
        if ({obs_std, obs_ldd, obs_err, obs_extra} !== 4'b1000) begin
            n_fail++; $display("FAIL store_done: got std/ldd/err/extra=%b expected 1000", {obs_std, obs_ldd, obs_err, obs_extra});
        end
        n_cmp++;
        if (obs_lat !== 5) begin n_fail++; $display("FAIL store_latency: got %0d expected 5", obs_lat); end
    endtask

    task automatic test_load();
        ld_addr = 32'h10; ld_req = 1'b1;
        master_serve(0, 128'h100, 1'b0);
        ld_req = 1'b0;
        n_cmp++;
        if (obs_to || obs_mode !== 2'b01 || obs_addrb !== 32'h10 || obs_addra !== 32'hF0) begin
            n_fail++; $display("FAIL load_issue: got to=%0d mode=%b b=%0h a=%0h expected 0 01 10 f0", obs_to, obs_mode, obs_addrb, obs_addra);
        end
        n_cmp++;
        if ({obs_ldd, obs_std, obs_err} !== 3'b100 || obs_ldr !== 128'h100) begin
            n_fail++; $display("FAIL load_done: got %b rdata=%0h expected 100 rdata=100", {obs_ldd, obs_std, obs_err}, obs_ldr);
        end
        n_cmp++;
        if (obs_lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d expected 2", obs_lat); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_mode [3];
        bit exp_last_st;
        do_reset();
        exp_last_st = 1'b1;
        ld_addr = 32'h200; st_addr = 32'h300; st_wdata = 128'h55;
        ld_req = 1'b1; st_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            // Both requesters are held high: the model alternates from the last grant.
            exp_last_st = ~exp_last_st;
            exp_mode[r] = exp_last_st ? 2'b10 : 2'b01;
            master_serve(r, 128'hA0 + 128'(r), 1'b0);
            if (r == 1) st_req = 1'b0;
            if (r == 2) ld_req = 1'b0;
            n_cmp++;
            if (obs_to || obs_mode !== exp_mode[r] || {obs_std, obs_ldd} !== {exp_last_st, ~exp_last_st}) begin
                n_fail++; $display("FAIL rr_round%0d: got to=%0d mode=%b std/ldd=%b%b expected mode=%b",
                                   r, obs_to, obs_mode, obs_std, obs_ldd, exp_mode[r]);
            end
        end
    endtask

    task automatic test_error();
        st_addr = 32'h44; st_wdata = 128'h77; st_req = 1'b1;
        master_serve(1, '0, 1'b1);
        st_req = 1'b0;
        n_cmp++;
        if (obs_to || {obs_std, obs_err, obs_extra} !== 3'b110) begin
            n_fail++; $display("FAIL error_pulse: got to=%0d std/err/extra=%b expected 110", obs_to, {obs_std, obs_err, obs_extra});
        end
        st_req = 1'b1;
        master_serve(0, '0, 1'b0);
        st_req = 1'b0;
        n_cmp++;
        if (obs_to || {obs_std, obs_err} !== 2'b10) begin
            n_fail++; $display("FAIL error_cleared: got to=%0d std/err=%b expected 10", obs_to, {obs_std, obs_err});
        end
    endtask

    task automatic test_input_change();
        int k;
        st_addr = 32'hA1; st_wdata = 128'hD1; st_req = 1'b1;
        k = 0;
        while (m_init_txn !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        st_addr = 32'hBAD; st_wdata = 128'hBAD; st_req = 1'b0;
        master_serve(2, '0, 1'b0);
        n_cmp++;
        if (obs_to || obs_addra !== 32'hA1 || obs_wdata !== 128'hD1 || obs_std !== 1'b1) begin
            n_fail++; $display("FAIL input_change: got to=%0d a=%0h w=%0h std=%b expected a1 d1 1",
                               obs_to, obs_addra, obs_wdata, obs_std);
        end
    endtask

    task automatic test_drop_before_grant();
        int bad;
        bad = 0;
        m_txn_done = 1'b1; ld_addr = 32'h99; ld_req = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (m_init_txn !== 1'b0) bad++; end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL init_while_done: got %0d cycles of init expected 0", bad); end
        ld_req = 1'b0; m_txn_done = 1'b0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_init_txn !== 1'b0 || ld_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL drop_before_grant: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int k, bad;
        st_addr = 32'h5; st_wdata = 128'h6; st_req = 1'b1;
        k = 0;
        while (m_init_txn !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_init_txn, m_mode, st_done, ld_done, err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_mid: got %b expected 000000", {m_init_txn, m_mode, st_done, ld_done, err});
        end
        reset = 1'b0; st_req = 1'b0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (st_done !== 1'b0 || ld_done !== 1'b0 || m_init_txn !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad); end
        ld_req = 1'b1; st_req = 1'b1;
        master_serve(0, 128'h1, 1'b0);
        ld_req = 1'b0; st_req = 1'b0;
        n_cmp++;
        if (obs_to || obs_mode !== 2'b01 || obs_ldd !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_tie: got to=%0d mode=%b ldd=%b expected 0 01 1", obs_to, obs_mode, obs_ldd);
        end
    endtask

    task automatic test_timeout();
        int k, when;
        bit seen;
        logic e, init;
        do_reset();
        st_addr = 32'h7; st_wdata = 128'h8; st_req = 1'b1;
        k = 0;
        while (m_init_txn !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        seen = 0; when = 0; e = 0; init = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (st_done === 1'b1 || ld_done === 1'b1) begin seen = 1; when = i; e = err; init = m_init_txn; end
        end
        st_req = 1'b0;
        n_cmp++;
`ifdef TXN_TIMEOUT_EN
        if (!seen || when != TO || e !== 1'b1 || init !== 1'b0) begin
            n_fail++; $display("FAIL timeout: got seen=%0d at=%0d err=%b init=%b expected 1 %0d 1 0", seen, when, e, init, TO);
        end
`else
        if (seen) begin n_fail++; $display("FAIL no_timeout: got done at cycle %0d expected none", when); end
`endif
        do_reset();
    endtask

    task automatic test_random();
        bit            exp_last_st, g_st, merr;
        logic [AW-1:0] exp_addra, exp_addrb, la, sa;
        logic [DW-1:0] exp_wdata, exp_ldr, sd, rd;
        logic [1:0]    rq;
        int            dly, bad;
        do_reset();
        exp_last_st = 1'b1; exp_addra = '0; exp_addrb = '0; exp_wdata = '0; exp_ldr = '0;
        bad = 0;
        for (int it = 0; it < 40; it++) begin
            rq   = 2'($urandom_range(1, 3));
            la   = $urandom; sa = $urandom;
            sd   = {$urandom, $urandom, $urandom, $urandom};
            rd   = {$urandom, $urandom, $urandom, $urandom};
            dly  = $urandom_range(0, 3);
            merr = 1'($urandom_range(0, 1));
            g_st = rq[1] && (!rq[0] || !exp_last_st);
            exp_last_st = g_st;
            if (g_st) begin exp_addra = sa; exp_wdata = sd; end
            else begin exp_addrb = la; exp_ldr = rd; end
            ld_req = rq[0]; st_req = rq[1]; ld_addr = la; st_addr = sa; st_wdata = sd;
            master_serve(dly, rd, merr);
            ld_req = 1'b0; st_req = 1'b0;
            n_cmp++;
            if (obs_to || obs_mode !== (g_st ? 2'b10 : 2'b01) || obs_addra !== exp_addra ||
                obs_addrb !== exp_addrb || obs_wdata !== exp_wdata || obs_ldr !== exp_ldr ||
                {obs_std, obs_ldd, obs_err, obs_extra} !== {g_st, ~g_st, merr, 1'b0} || obs_lat !== dly + 2) begin
                n_fail++; bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d: got to=%0d mode=%b a=%0h b=%0h ldr=%0h flags=%b lat=%0d expected st=%0d a=%0h b=%0h ldr=%0h err=%0d lat=%0d",
                             it, obs_to, obs_mode, obs_addra, obs_addrb, obs_ldr,
                             {obs_std, obs_ldd, obs_err, obs_extra}, obs_lat,
                             g_st, exp_addra, exp_addrb, exp_ldr, merr, dly + 2);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; ld_req = 1'b0; st_req = 1'b0; m_txn_done = 1'b0; m_error = 1'b0;
        ld_addr = '0; st_addr = '0; st_wdata = '0; m_rdata = '0;
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_error();
        test_input_change();
        test_drop_before_grant();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
